// File: rtl/linear_bias_add.sv
// Streaming bias-add: joins data_in and bias beats, aligns fractional points, casts and buffers in a 2-entry FIFO.
// Define LINEAR_BIAS_ADD_SATURATE_EN to saturate the output cast instead of wrapping.
module linear_bias_add #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 3,
    parameter int PARALLELISM          = 1,
    parameter int TENSOR_SIZE_DIM_0    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM-1:0],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM-1:0],
    input  logic                            bias_valid,
    output logic                            bias_ready,
    output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM-1:0],
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last
);

    localparam int FRAC   = (DATA_IN_PRECISION_1 > BIAS_PRECISION_1) ? DATA_IN_PRECISION_1 : BIAS_PRECISION_1;
    localparam int DI_SH  = FRAC - DATA_IN_PRECISION_1;
    localparam int B_SH   = FRAC - BIAS_PRECISION_1;
    localparam int DI_AW  = DATA_IN_PRECISION_0 + DI_SH;
    localparam int B_AW   = BIAS_PRECISION_0 + B_SH;
    localparam int SUM_W  = ((DI_AW > B_AW) ? DI_AW : B_AW) + 1;
    localparam int SH_R   = (FRAC > DATA_OUT_PRECISION_1) ? FRAC - DATA_OUT_PRECISION_1 : 0;
    localparam int SH_L   = (DATA_OUT_PRECISION_1 > FRAC) ? DATA_OUT_PRECISION_1 - FRAC : 0;
    localparam int CAST_W = SUM_W + SH_L;
    localparam int OUT_W  = DATA_OUT_PRECISION_0;
    localparam int WIDE   = (CAST_W > OUT_W) ? CAST_W : OUT_W;
    localparam int BEATS  = TENSOR_SIZE_DIM_0 / PARALLELISM;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

`ifdef LINEAR_BIAS_ADD_SATURATE_EN
    localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic signed [WIDE-1:0]  op_a   [PARALLELISM];
    logic signed [WIDE-1:0]  op_b   [PARALLELISM];
    logic signed [WIDE-1:0]  scaled [PARALLELISM];
    logic        [OUT_W-1:0] cast   [PARALLELISM];

    logic [OUT_W-1:0]  mem_data [2][PARALLELISM];
    logic              mem_last [2];
    logic              head;
    logic              tail;
    logic [1:0]        count;
    logic [BEAT_W-1:0] beat;
    logic              full;
    logic              fire;
    logic              pop;
    logic              is_last;

    assign full           = (count == 2'd2);
    assign data_in_ready  = !full;
    assign bias_ready     = !full;
    assign fire           = data_in_valid & bias_valid & !full;
    assign data_out_valid = (count != 2'd0);
    assign pop            = data_out_valid & data_out_ready;
    assign tail           = head ^ count[0];
    assign is_last        = (beat == LAST_BEAT);

    // Operands are widened before shifting so neither the alignment nor the sum can lose bits.
    always_comb begin
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            op_a[i]   = WIDE'($signed(data_in[i])) <<< DI_SH;
            op_b[i]   = WIDE'($signed(bias[i])) <<< B_SH;
            scaled[i] = ((op_a[i] + op_b[i]) >>> SH_R) <<< SH_L;
`ifdef LINEAR_BIAS_ADD_SATURATE_EN
            if (scaled[i] > SAT_MAX) begin
                cast[i] = OUT_W'(SAT_MAX);
            end else if (scaled[i] < SAT_MIN) begin
                cast[i] = OUT_W'(SAT_MIN);
            end else begin
                cast[i] = OUT_W'(scaled[i]);
            end
`else
            cast[i] = OUT_W'(scaled[i]);
`endif
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            data_out[i] = mem_data[head][i];
        end
    end
    assign data_out_last = mem_last[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned e = 0; e < 2; e++) begin
                for (int unsigned i = 0; i < PARALLELISM; i++) begin
                    mem_data[e][i] <= '0;
                end
                mem_last[e] <= 1'b0;
            end
            head  <= 1'b0;
            count <= '0;
            beat  <= '0;
        end else begin
            if (fire) begin
                for (int unsigned i = 0; i < PARALLELISM; i++) begin
                    mem_data[tail][i] <= cast[i];
                end
                mem_last[tail] <= is_last;
                beat           <= is_last ? '0 : beat + 1'b1;
            end
            if (pop) begin
                head <= ~head;
            end
            if (fire && !pop) begin
                count <= count + 2'd1;
            end else if (!fire && pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_linear_bias_add.sv
// Directed bench for linear_bias_add: a 4-element-row instance for join/buffer/row behaviour and a
// 5-fractional-bit bias instance for alignment and truncation.
module tb_linear_bias_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [15:0] a_din [1];
    logic [15:0] a_bias [1];
    logic [15:0] a_dout [1];
    logic        a_din_v, a_din_rdy, a_bias_v, a_bias_rdy, a_dout_v, a_dout_rdy, a_dout_last;

    logic [15:0] b_din [1];
    logic [15:0] b_bias [1];
    logic [15:0] b_dout [1];
    logic        b_din_v, b_din_rdy, b_bias_v, b_bias_rdy, b_dout_v, b_dout_rdy, b_dout_last;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    linear_bias_add #(.TENSOR_SIZE_DIM_0(4)) u_dut_row (
        .clk(clk), .rst(rst),
        .data_in(a_din), .data_in_valid(a_din_v), .data_in_ready(a_din_rdy),
        .bias(a_bias), .bias_valid(a_bias_v), .bias_ready(a_bias_rdy),
        .data_out(a_dout), .data_out_valid(a_dout_v), .data_out_ready(a_dout_rdy),
        .data_out_last(a_dout_last)
    );

    linear_bias_add #(.BIAS_PRECISION_1(5)) u_dut_align (
        .clk(clk), .rst(rst),
        .data_in(b_din), .data_in_valid(b_din_v), .data_in_ready(b_din_rdy),
        .bias(b_bias), .bias_valid(b_bias_v), .bias_ready(b_bias_rdy),
        .data_out(b_dout), .data_out_valid(b_dout_v), .data_out_ready(b_dout_rdy),
        .data_out_last(b_dout_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_a(input logic [15:0] d, input logic [15:0] b, input logic dv, input logic bv);
        a_din[0] = d; a_bias[0] = b; a_din_v = dv; a_bias_v = bv;
    endtask

    logic [15:0] exp_ovf_pos, exp_ovf_neg;
    logic [15:0] al_d [4];
    logic [15:0] al_b [4];
    logic [15:0] al_e [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LINEAR_BIAS_ADD_SATURATE_EN
        exp_ovf_pos = 16'h7FFF; exp_ovf_neg = 16'h8000;
`else
        exp_ovf_pos = 16'h8010; exp_ovf_neg = 16'h7FF8;
`endif
        al_d = '{16'h0008, 16'h0000, 16'h0000, 16'hFFF8};
        al_b = '{16'h0020, 16'hFFFF, 16'h0003, 16'h0000};
        al_e = '{16'h0010, 16'hFFFF, 16'h0000, 16'hFFF8};

        rst = 1'b0;
        drive_a(16'h0, 16'h0, 1'b0, 1'b0);
        a_dout_rdy = 1'b1;
        b_din[0] = '0; b_bias[0] = '0; b_din_v = 1'b0; b_bias_v = 1'b0; b_dout_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", a_dout_v, 0);
        check("rst_last", a_dout_last, 0);
        check("rst_data", a_dout[0], 0);
        check("rst_valid_b", b_dout_v, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_din_ready", a_din_rdy, 1);
        check("rst_bias_ready", a_bias_rdy, 1);

        // single beat, row beat 0
        drive_a(16'h0010, 16'h0008, 1'b1, 1'b1);
        @(negedge clk);
        check("single_valid", a_dout_v, 1);
        check("single_data", a_dout[0], 16'h0018);
        check("single_last", a_dout_last, 0);
        drive_a(16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_drain", a_dout_v, 0);

        // overflow and zero crossing, row beats 1..3
        drive_a(16'h7FF0, 16'h0020, 1'b1, 1'b1);
        @(negedge clk);
        check("ovf_pos", a_dout[0], exp_ovf_pos);
        drive_a(16'h8000, 16'hFFF8, 1'b1, 1'b1);
        @(negedge clk);
        check("ovf_neg", a_dout[0], exp_ovf_neg);
        check("ovf_neg_last", a_dout_last, 0);
        drive_a(16'h0010, 16'hFFF0, 1'b1, 1'b1);
        @(negedge clk);
        check("zero_sum", a_dout[0], 16'h0000);
        check("row_last_beat3", a_dout_last, 1);
        drive_a(16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);

        // alignment on the 5-fractional-bit bias instance
        for (int i = 0; i < 4; i++) begin
            b_din[0] = al_d[i]; b_bias[0] = al_b[i]; b_din_v = 1'b1; b_bias_v = 1'b1;
            @(negedge clk);
            check($sformatf("align_valid_%0d", i), b_dout_v, 1);
            check($sformatf("align_data_%0d", i), b_dout[0], al_e[i]);
        end
        b_din_v = 1'b0; b_bias_v = 1'b0;

        // join: data without bias never fires
        drive_a(16'h1234, 16'h0008, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("join_no_out_%0d", i), a_dout_v, 0);
            check($sformatf("join_ready_%0d", i), a_din_rdy, 1);
        end

        // backpressure: three beats offered, two accepted
        a_dout_rdy = 1'b0;
        drive_a(16'h0100, 16'h0008, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_first_valid", a_dout_v, 1);
        check("bp_ready_after_1", a_din_rdy, 1);
        drive_a(16'h0200, 16'h0008, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_din_ready_full", a_din_rdy, 0);
        check("bp_bias_ready_full", a_bias_rdy, 0);
        drive_a(16'h0300, 16'h0008, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("bp_hold_ready", a_din_rdy, 0);
        check("bp_hold_data", a_dout[0], 16'h0108);
        check("bp_hold_last", a_dout_last, 0);
        a_dout_rdy = 1'b1;
        @(negedge clk);
        check("bp_out2_data", a_dout[0], 16'h0208);
        check("bp_ready_restored", a_din_rdy, 1);
        @(negedge clk);
        check("bp_out3_valid", a_dout_v, 1);
        check("bp_out3_data", a_dout[0], 16'h0308);
        drive_a(16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_drained", a_dout_v, 0);

        // reset with two entries buffered (row beat counter sits at 3 before this)
        a_dout_rdy = 1'b0;
        drive_a(16'h0040, 16'h0008, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("mid_full", a_din_rdy, 0);
        check("mid_valid_before", a_dout_v, 1);
        drive_a(16'h0, 16'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_async_valid", a_dout_v, 0);
        check("mid_async_data", a_dout[0], 0);
        check("mid_async_last", a_dout_last, 0);
        @(negedge clk);
        rst = 1'b1;
        a_dout_rdy = 1'b1;

        // eight continuous beats: last on outputs 3 and 7 only
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive_a(16'(8 * k), 16'h0008, 1'b1, 1'b1);
            else drive_a(16'h0, 16'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (k < 8) begin
                check($sformatf("row_valid_%0d", k), a_dout_v, 1);
                check($sformatf("row_data_%0d", k), a_dout[0], 32'(8 * k + 8));
                check($sformatf("row_last_%0d", k), a_dout_last, ((k % 4) == 3) ? 1 : 0);
            end else begin
                check("row_drained", a_dout_v, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
